// File: rtl/run_event_counter_if.sv
// Bundle between the run detector / board pins and the run event counter.
// master drives z, clear and hold; slave is the counter and drives everything else.
interface run_event_counter_if #(
  parameter int RUN_W = 8
);
  logic             z;
  logic             clear;
  logic             hold;
  logic [3:0]       tens;
  logic [3:0]       units;
  logic             overflow;
  logic             event_pulse;
  logic [RUN_W-1:0] last_len;
  logic [6:0]       seg_tens;
  logic [6:0]       seg_units;

  modport master (
    output z, clear, hold,
    input  tens, units, overflow, event_pulse, last_len, seg_tens, seg_units
  );

  modport slave (
    input  z, clear, hold,
    output tens, units, overflow, event_pulse, last_len, seg_tens, seg_units
  );
endinterface

// File: rtl/run_event_counter.sv
// Counts rising edges of the run-detector level z as a BCD 00-99 count, shows it on
// two 7-segment digits, and measures the length of the most recent z-high interval.
module run_event_counter #(
  parameter int RUN_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                clock,
  input logic                reset,
  run_event_counter_if.slave bus
);

  logic             z_q;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             overflow_q, overflow_d;
  logic             event_pulse_q, event_pulse_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0] last_len_q, last_len_d;
  logic             rise;

  assign rise = bus.z & ~z_q;

  // Clear beats a coincident rise; hold only blocks counting, never the edge tracking.
  always_comb begin
    tens_d        = tens_q;
    units_d       = units_q;
    overflow_d    = overflow_q;
    event_pulse_d = 1'b0;
    if (bus.clear) begin
      tens_d     = 4'd0;
      units_d    = 4'd0;
      overflow_d = 1'b0;
    end else if (rise && !bus.hold) begin
      event_pulse_d = 1'b1;
      if (units_q != 4'd9) begin
        units_d = units_q + 4'd1;
      end else begin
        units_d = 4'd0;
        if (tens_q != 4'd9) begin
          tens_d = tens_q + 4'd1;
        end else begin
          tens_d     = 4'd0;
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      z_q           <= 1'b0;
      tens_q        <= 4'd0;
      units_q       <= 4'd0;
      overflow_q    <= 1'b0;
      event_pulse_q <= 1'b0;
    end else begin
      z_q           <= bus.z;
      tens_q        <= tens_d;
      units_q       <= units_d;
      overflow_q    <= overflow_d;
      event_pulse_q <= event_pulse_d;
    end
  end

  // run_cnt holds the number of edges z has been sampled high; it is latched on the fall.
  always_comb begin
    run_cnt_d  = run_cnt_q;
    last_len_d = last_len_q;
    if (bus.clear) begin
      run_cnt_d  = '0;
      last_len_d = '0;
    end else begin
      if (bus.z) begin
        run_cnt_d = (run_cnt_q == {RUN_W{1'b1}}) ? run_cnt_q : run_cnt_q + RUN_W'(1);
      end else begin
        run_cnt_d = '0;
      end
      if (!bus.z && z_q) begin
        last_len_d = run_cnt_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_q  <= '0;
      last_len_q <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      last_len_q <= last_len_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b0111111;
      4'd1:    code = 7'b0000110;
      4'd2:    code = 7'b1011011;
      4'd3:    code = 7'b1001111;
      4'd4:    code = 7'b1100110;
      4'd5:    code = 7'b1101101;
      4'd6:    code = 7'b1111101;
      4'd7:    code = 7'b0000111;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1101111;
      default: code = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~code : code;
  endfunction

  assign bus.tens        = tens_q;
  assign bus.units       = units_q;
  assign bus.overflow    = overflow_q;
  assign bus.event_pulse = event_pulse_q;
  assign bus.last_len    = last_len_q;
  assign bus.seg_tens    = seg7(tens_q);
  assign bus.seg_units   = seg7(units_q);

endmodule
